// File: rtl/line_buffer_3row_if.sv
// line_buffer_3row_if: pixel stream in, three vertically aligned pixels out.
// master = pixel source side, slave = line buffer side.
interface line_buffer_3row_if #(
   parameter int WIDTH = 24
);
   logic             valid_in;
   logic             sof;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout1;
   logic [WIDTH-1:0] dout2;
   logic [WIDTH-1:0] dout3;
   logic             valid_out;
   logic             eol_out;
   logic             eof_out;

   modport master (
      output valid_in, sof, din,
      input  dout1, dout2, dout3, valid_out, eol_out, eof_out
   );

   modport slave (
      input  valid_in, sof, din,
      output dout1, dout2, dout3, valid_out, eol_out, eof_out
   );
endinterface

// File: rtl/line_buffer_3row.sv
// line_buffer_3row: two-line delay feeding a 3x3 window stage.
// Each accepted pixel at column c presents rows y-2, y-1 and y of that column
// one clock later on dout1/dout2/dout3.
// Optional build macro LINE_BUF_ROW_GATE_EN: suppress valid_out/eol_out/eof_out
// while the output row is 0 or 1 (memories are still written during those rows).
module line_buffer_3row #(
   parameter int WIDTH      = 24,
   parameter int PIC_WIDTH  = 480,
   parameter int PIC_HEIGHT = 272
) (
   input logic               clk,
   input logic               rst_n,
   line_buffer_3row_if.slave lb
);

   localparam int CW = (PIC_WIDTH  > 2) ? $clog2(PIC_WIDTH)  : 1;
   localparam int RW = $clog2(PIC_HEIGHT);
   localparam logic [CW-1:0] LAST_COL = CW'(PIC_WIDTH - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(PIC_HEIGHT - 1);

   // position counters of the next pixel to arrive
   logic [CW-1:0]    r_col;
   logic [RW-1:0]    r_row;

   // line delay memories: mem0 holds row y-1, mem1 holds row y-2 (not reset)
   logic [WIDTH-1:0] r_mem0 [PIC_WIDTH];
   logic [WIDTH-1:0] r_mem1 [PIC_WIDTH];

   // output registers
   logic [WIDTH-1:0] r_dout1_p1;
   logic [WIDTH-1:0] r_dout2_p1;
   logic [WIDTH-1:0] r_dout3_p1;
   logic             r_vld_p1;
   logic             r_eol_p1;
   logic             r_eof_p1;

   // effective position of the current pixel (sof overrides the counters)
   logic [CW-1:0]    w_col;
   logic [RW-1:0]    w_row;
   logic [CW-1:0]    w_col_nxt;
   logic [RW-1:0]    w_row_nxt;
   logic             w_eol;
   logic             w_eof;
   logic             w_emit;
   logic [WIDTH-1:0] w_rd0;
   logic [WIDTH-1:0] w_rd1;

   // resolve the current pixel position and the position that follows it
   always_comb begin
      w_col     = r_col;
      w_row     = r_row;
      if (lb.sof) begin
         w_col = '0;
         w_row = '0;
      end
      w_eol     = (w_col == LAST_COL);
      w_eof     = w_eol && (w_row == LAST_ROW);
      w_col_nxt = w_col + CW'(1);
      w_row_nxt = w_row;
      if (w_eol) begin
         w_col_nxt = '0;
         w_row_nxt = (w_row == LAST_ROW) ? '0 : (w_row + RW'(1));
      end
`ifdef LINE_BUF_ROW_GATE_EN
      w_emit    = lb.valid_in && (w_row >= RW'(2));
`else
      w_emit    = lb.valid_in;
`endif
   end

   // old contents of the current column, read before this cycle's write
   assign w_rd0 = r_mem0[w_col];
   assign w_rd1 = r_mem1[w_col];

   // advance the raster position on each accepted pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (lb.valid_in) begin
         r_col <= w_col_nxt;
         r_row <= w_row_nxt;
      end
   end

   // shift the column down one row: mem0 -> mem1, din -> mem0
   always_ff @(posedge clk) begin
      if (lb.valid_in) begin
         r_mem1[w_col] <= w_rd0;
         r_mem0[w_col] <= lb.din;
      end
   end

   // register the three aligned pixels and their framing flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout1_p1 <= '0;
         r_dout2_p1 <= '0;
         r_dout3_p1 <= '0;
         r_vld_p1   <= 1'b0;
         r_eol_p1   <= 1'b0;
         r_eof_p1   <= 1'b0;
      end else begin
         r_vld_p1 <= w_emit;
         r_eol_p1 <= w_emit && w_eol;
         r_eof_p1 <= w_emit && w_eof;
         if (lb.valid_in) begin
            r_dout1_p1 <= w_rd1;
            r_dout2_p1 <= w_rd0;
            r_dout3_p1 <= lb.din;
         end
      end
   end

   assign lb.dout1     = r_dout1_p1;
   assign lb.dout2     = r_dout2_p1;
   assign lb.dout3     = r_dout3_p1;
   assign lb.valid_out = r_vld_p1;
   assign lb.eol_out   = r_eol_p1;
   assign lb.eof_out   = r_eof_p1;

endmodule

// File: tb/tb_line_buffer_3row.sv
// tb_line_buffer_3row: randomized and pattern-frame stimulus against a
// column-history reference model of the line buffer.
module tb_line_buffer_3row;
   localparam int W  = 24;
   localparam int PW = 12;
   localparam int PH = 8;
`ifdef LINE_BUF_ROW_GATE_EN
   localparam bit GATE = 1'b1;
`else
   localparam bit GATE = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   line_buffer_3row_if #(.WIDTH(W)) vif ();

   line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .lb    (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: raster position and per-column history of written pixels
   int          m_col, m_row;
   logic [W-1:0] h0 [PW];
   logic [W-1:0] h1 [PW];
   int          hcnt [PW];
   logic [W-1:0] e_d1, e_d2, e_d3;
   bit          k1, k2;
   bit          e_vld, e_eol, e_eof;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_col = 0; m_row = 0;
      e_d1 = '0; e_d2 = '0; e_d3 = '0;
      k1 = 1'b1; k2 = 1'b1;
      e_vld = 1'b0; e_eol = 1'b0; e_eof = 1'b0;
   endtask

   task automatic check_outputs();
      chk("valid_out", 32'(vif.valid_out), 32'(e_vld));
      chk("eol_out",   32'(vif.eol_out),   32'(e_eol));
      chk("eof_out",   32'(vif.eof_out),   32'(e_eof));
      chk("dout3",     32'(vif.dout3),     32'(e_d3));
      if (k2) chk("dout2", 32'(vif.dout2), 32'(e_d2));
      if (k1) chk("dout1", 32'(vif.dout1), 32'(e_d1));
   endtask

   // one clock: drive at negedge, predict, check 1 time unit after posedge
   task automatic step(input bit v, input bit s, input logic [W-1:0] d);
      @(negedge clk);
      vif.valid_in = v;
      vif.sof      = s;
      vif.din      = d;
      if (v) begin
         if (s) begin
            m_col = 0; m_row = 0;
         end
         e_d3 = d;
         e_d2 = h0[m_col]; k2 = (hcnt[m_col] >= 1);
         e_d1 = h1[m_col]; k1 = (hcnt[m_col] >= 2);
         h1[m_col] = h0[m_col];
         h0[m_col] = d;
         if (hcnt[m_col] < 2) hcnt[m_col]++;
         e_vld = GATE ? (m_row >= 2) : 1'b1;
         e_eol = e_vld && (m_col == PW - 1);
         e_eof = e_eol && (m_row == PH - 1);
         m_col++;
         if (m_col == PW) begin
            m_col = 0;
            m_row = (m_row == PH - 1) ? 0 : m_row + 1;
         end
      end else begin
         e_vld = 1'b0; e_eol = 1'b0; e_eof = 1'b0;
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   // asynchronous reset while the stream is running
   task automatic async_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      vif.valid_in = 1'b0;
      vif.sof = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // one pattern frame, pixel = {row, col, 8'h00}; optional idle cycle after each pixel
   task automatic pattern_frame(input bit first_sof, input bit toggle, input string name);
      int pulses;
      int first_idx;
      int idx;
      logic [7:0] rb, cb;
      pulses = 0; first_idx = 0; idx = 0;
      for (int r = 0; r < PH; r++) begin
         for (int c = 0; c < PW; c++) begin
            rb = 8'(r); cb = 8'(c);
            idx++;
            step(1'b1, first_sof && r == 0 && c == 0, {rb, cb, 8'h00});
            if (vif.valid_out) begin
               pulses++;
               if (first_idx == 0) first_idx = idx;
            end
            if (r == 5 && c == 10) begin
               chk({name, "_d1_at_5_10"}, 32'(vif.dout1), 32'h030A00);
               chk({name, "_d2_at_5_10"}, 32'(vif.dout2), 32'h040A00);
               chk({name, "_d3_at_5_10"}, 32'(vif.dout3), 32'h050A00);
            end
            if (r == PH - 1 && c == PW - 1) begin
               chk({name, "_eol_last"}, 32'(vif.eol_out), 32'd1);
               chk({name, "_eof_last"}, 32'(vif.eof_out), 32'd1);
            end
            if (toggle) step(1'b0, 1'b0, W'($urandom));
         end
      end
      chk({name, "_pulses"}, 32'(pulses), GATE ? 32'(PW * (PH - 2)) : 32'(PW * PH));
      chk({name, "_first_vld"}, 32'(first_idx), GATE ? 32'(2 * PW + 1) : 32'd1);
   endtask

   initial begin
      bit v, s;
      int eol_pos;
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      vif.valid_in = 1'b0;
      vif.sof = 1'b0;
      vif.din = '0;
      for (int i = 0; i < PW; i++) begin
         h0[i] = '0; h1[i] = '0; hcnt[i] = 0;
      end
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // continuous frame, then toggled frame wrapping from eof with no sof
      pattern_frame(1'b1, 1'b0, "cont");
      pattern_frame(1'b0, 1'b1, "toggle");

      // mid-frame sof realigns; eol on its PW-th pixel
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'($urandom));
      eol_pos = 0;
      for (int i = 1; i <= PW; i++) begin
         step(1'b1, i == 1, W'($urandom));
         if (vif.eol_out && eol_pos == 0) eol_pos = i;
      end
      if (!GATE) chk("sof_eol_pos", 32'(eol_pos), 32'(PW));

      // random traffic with occasional sof
      for (int i = 0; i < 500; i++) begin
         v = ($urandom % 4) != 0;
         s = v && (($urandom % 70) == 0);
         step(v, s, W'($urandom));
      end

      // reset mid-stream; next pixel counts as (0,0)
      async_reset();
      for (int i = 0; i < 400; i++) begin
         v = ($urandom % 3) != 0;
         s = v && (($urandom % 90) == 0);
         step(v, s, W'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   // safety bound on total runtime
   initial begin
      #400000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end
endmodule
